// File: rtl/riscv_id_ex_stage.sv
// ---------------------------------------------------------------------------
// riscv_id_ex_stage
//
// ID/EX pipeline register. It sits directly in front of the ALU. It captures
// the decoded instruction from ID and selects the two ALU operands from one
// of these sources:
//   - the register file,
//   - the PC,
//   - the immediate,
//   - data forwarded from the MEM and WB stages.
// It also detects RAW hazards, drives the ID stall, and loads bubbles on
// stall or flush.
//
// Build option:
//   RISCV_ID_EX_FWD_EN  defined   : MEM/WB forwarding muxes are present, and
//                                   only a load-use dependency stalls ID.
//   RISCV_ID_EX_FWD_EN  undefined : no forwarding. ID stalls while any used,
//                                   nonzero source matches a pending write in
//                                   EX, MEM or WB.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   id_*                        decoded instruction and register-file read data
//   flush                       kill the instruction entering EX
//   hold                        freeze the whole stage
//   mem_rd/_reg_write/_result   EX/MEM producer
//   wb_rd/_reg_write/_data      MEM/WB producer
//   stall_id                    ID and IF must hold (combinational)
//   ex_valid/_reg_write/_mem_read/_rd/_alu_op   EX control
//   operand_1, operand_2        ALU operands
//   ex_store_data               forwarded rs2 value for stores
// ---------------------------------------------------------------------------

`ifndef ALU_OP_LEN
`define ALU_OP_LEN 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 4'd0
`endif

module riscv_id_ex_stage (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [`ALU_OP_LEN-1:0] id_alu_op,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [31:0]            id_rs1_data,
    input  logic [31:0]            id_rs2_data,
    input  logic [31:0]            id_pc,
    input  logic [31:0]            id_imm,
    input  logic                   id_src1_pc,
    input  logic                   id_src2_imm,
    input  logic [4:0]             id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   flush,
    input  logic                   hold,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_reg_write,
    input  logic [31:0]            mem_result,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_reg_write,
    input  logic [31:0]            wb_data,
    output logic                   stall_id,
    output logic                   ex_valid,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic [4:0]             ex_rd,
    output logic [`ALU_OP_LEN-1:0] ex_alu_op,
    output logic [31:0]            operand_1,
    output logic [31:0]            operand_2,
    output logic [31:0]            ex_store_data
);

    localparam int DATA_W = 32;

    logic                   valid_p1;
    logic [`ALU_OP_LEN-1:0] alu_op_p1;
    logic [4:0]             rs1_p1;
    logic [4:0]             rs2_p1;
    logic                   uses_rs1_p1;
    logic                   uses_rs2_p1;
    logic [DATA_W-1:0]      rs1_data_p1;
    logic [DATA_W-1:0]      rs2_data_p1;
    logic [DATA_W-1:0]      pc_p1;
    logic [DATA_W-1:0]      imm_p1;
    logic                   src1_pc_p1;
    logic                   src2_imm_p1;
    logic [4:0]             rd_p1;
    logic                   reg_write_p1;
    logic                   mem_read_p1;

    logic [DATA_W-1:0]      fwd_rs1;
    logic [DATA_W-1:0]      fwd_rs2;
    logic                   hazard;

    // A source creates a dependency only if it is actually read and is not x0.
    function automatic logic src_hit(input logic       uses,
                                     input logic [4:0] rs,
                                     input logic       wr_en,
                                     input logic [4:0] wr_rd);
        return uses && (rs != 5'd0) && wr_en && (rs == wr_rd);
    endfunction

    // ---- ID -> EX register (stage p1) ----
    // Priority: reset, flush, hold, stall, load. A bubble clears only the
    // control fields. The data fields are don't-care in a bubble, so they
    // keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_p1     <= 1'b0;
            alu_op_p1    <= `ALU_OP_ADD;
            rs1_p1       <= 5'd0;
            rs2_p1       <= 5'd0;
            uses_rs1_p1  <= 1'b0;
            uses_rs2_p1  <= 1'b0;
            rs1_data_p1  <= '0;
            rs2_data_p1  <= '0;
            pc_p1        <= '0;
            imm_p1       <= '0;
            src1_pc_p1   <= 1'b0;
            src2_imm_p1  <= 1'b0;
            rd_p1        <= 5'd0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
        end else if (flush || (!hold && stall_id)) begin
            valid_p1     <= 1'b0;
            alu_op_p1    <= `ALU_OP_ADD;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
        end else if (!hold) begin
            valid_p1     <= id_valid;
            alu_op_p1    <= id_alu_op;
            rs1_p1       <= id_rs1;
            rs2_p1       <= id_rs2;
            uses_rs1_p1  <= id_uses_rs1;
            uses_rs2_p1  <= id_uses_rs2;
            rs1_data_p1  <= id_rs1_data;
            rs2_data_p1  <= id_rs2_data;
            pc_p1        <= id_pc;
            imm_p1       <= id_imm;
            src1_pc_p1   <= id_src1_pc;
            src2_imm_p1  <= id_src2_imm;
            rd_p1        <= id_rd;
            // An empty slot must never write a register or touch memory.
            reg_write_p1 <= id_valid && id_reg_write;
            mem_read_p1  <= id_valid && id_mem_read;
        end
    end

    assign ex_valid     = valid_p1;
    assign ex_alu_op    = alu_op_p1;
    assign ex_rd        = rd_p1;
    assign ex_reg_write = reg_write_p1;
    assign ex_mem_read  = mem_read_p1;

`ifdef RISCV_ID_EX_FWD_EN
    // ---- EX operand forwarding ----
    // The youngest producer (MEM) takes precedence over WB. x0 is never
    // forwarded.
    always_comb begin
        fwd_rs1 = rs1_data_p1;
        if (src_hit(1'b1, rs1_p1, mem_reg_write, mem_rd))
            fwd_rs1 = mem_result;
        else if (src_hit(1'b1, rs1_p1, wb_reg_write, wb_rd))
            fwd_rs1 = wb_data;

        fwd_rs2 = rs2_data_p1;
        if (src_hit(1'b1, rs2_p1, mem_reg_write, mem_rd))
            fwd_rs2 = mem_result;
        else if (src_hit(1'b1, rs2_p1, wb_reg_write, wb_rd))
            fwd_rs2 = wb_data;
    end

    // Only a load in EX is unresolved. Its data reaches EX through WB
    // forwarding once a single bubble has been inserted.
    always_comb begin
        hazard = 1'b0;
        if (valid_p1 && mem_read_p1 && (rd_p1 != 5'd0))
            hazard = src_hit(id_uses_rs1, id_rs1, 1'b1, rd_p1) ||
                     src_hit(id_uses_rs2, id_rs2, 1'b1, rd_p1);
    end

    logic unused_regs;
    assign unused_regs = uses_rs1_p1 ^ uses_rs2_p1;
`else
    // ---- EX operands without forwarding ----
    assign fwd_rs1 = rs1_data_p1;
    assign fwd_rs2 = rs2_data_p1;

    // Without forwarding, ID waits until every producer has left the
    // pipeline and the register file holds the new value.
    always_comb begin
        hazard = src_hit(id_uses_rs1, id_rs1, valid_p1 && reg_write_p1, rd_p1) ||
                 src_hit(id_uses_rs2, id_rs2, valid_p1 && reg_write_p1, rd_p1) ||
                 src_hit(id_uses_rs1, id_rs1, mem_reg_write, mem_rd)           ||
                 src_hit(id_uses_rs2, id_rs2, mem_reg_write, mem_rd)           ||
                 src_hit(id_uses_rs1, id_rs1, wb_reg_write, wb_rd)             ||
                 src_hit(id_uses_rs2, id_rs2, wb_reg_write, wb_rd);
    end

    logic unused_fwd;
    assign unused_fwd = ^{mem_result, wb_data, rs1_p1, rs2_p1,
                          uses_rs1_p1, uses_rs2_p1};
`endif

    // A flushed ID instruction is dead, so it must not hold the front end.
    assign stall_id = id_valid && hazard && !flush;

    assign operand_1     = src1_pc_p1  ? pc_p1  : fwd_rs1;
    assign operand_2     = src2_imm_p1 ? imm_p1 : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
`timescale 1ns/1ps

`ifndef ALU_OP_LEN
`define ALU_OP_LEN 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 4'd0
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 4'd1
`endif

module tb_riscv_id_ex_stage;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   id_valid;
    logic [`ALU_OP_LEN-1:0] id_alu_op;
    logic [4:0]             id_rs1, id_rs2, id_rd;
    logic                   id_uses_rs1, id_uses_rs2;
    logic [31:0]            id_rs1_data, id_rs2_data, id_pc, id_imm;
    logic                   id_src1_pc, id_src2_imm, id_reg_write, id_mem_read;
    logic                   flush, hold;
    logic [4:0]             mem_rd, wb_rd;
    logic                   mem_reg_write, wb_reg_write;
    logic [31:0]            mem_result, wb_data;
    logic                   stall_id, ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]             ex_rd;
    logic [`ALU_OP_LEN-1:0] ex_alu_op;
    logic [31:0]            operand_1, operand_2, ex_store_data;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .hold(hold),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .operand_1(operand_1), .operand_2(operand_2), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; drive and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [`ALU_OP_LEN-1:0] op,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic s1pc, input logic s2imm,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v;     id_alu_op = op;
        id_rs1 = rs1;     id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rs1_data = d1; id_rs2_data = d2;
        id_pc = pc;       id_imm = imm;
        id_src1_pc = s1pc; id_src2_imm = s2imm;
        id_rd = rd;       id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic clr_fwd();
        mem_rd = 5'd0; mem_reg_write = 1'b0; mem_result = 32'h0;
        wb_rd = 5'd0;  wb_reg_write = 1'b0;  wb_data = 32'h0;
    endtask

    initial begin
        // Reset must win over a valid ID instruction.
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        clr_fwd();
        set_id(1, `ALU_OP_SUB, 5'd1, 5'd2, 1, 1, 32'h1111, 32'h2222,
               32'h3333, 32'h4444, 0, 0, 5'd9, 1, 1);
        tick(); tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
        chk("rst_ex_mem_read", 32'(ex_mem_read), 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_ex_alu_op", 32'(ex_alu_op), 32'(`ALU_OP_ADD));
        chk("rst_operand_1", operand_1, 32'd0);
        chk("rst_operand_2", operand_2, 32'd0);
        chk("rst_store_data", ex_store_data, 32'd0);
        chk("rst_stall_id", 32'(stall_id), 32'd0);
        rst = 1'b0;

        // add x3,x1,x2 with no hazards
        set_id(1, `ALU_OP_ADD, 5'd1, 5'd2, 1, 1, 32'd5, 32'd7,
               32'h100, 32'h0, 0, 0, 5'd3, 1, 0);
        settle();
        chk("add_stall_id", 32'(stall_id), 32'd0);
        tick();
        // PC/imm operand selection, SUB op, sources not used
        set_id(1, `ALU_OP_SUB, 5'd10, 5'd11, 0, 0, 32'hAA, 32'h55,
               32'h1000, 32'h20, 1, 1, 5'd12, 1, 0);
        settle();
        chk("add_operand_1", operand_1, 32'd5);
        chk("add_operand_2", operand_2, 32'd7);
        chk("add_alu_op", 32'(ex_alu_op), 32'(`ALU_OP_ADD));
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        chk("add_ex_rd", 32'(ex_rd), 32'd3);
        chk("add_ex_reg_write", 32'(ex_reg_write), 32'd1);
        chk("add_ex_mem_read", 32'(ex_mem_read), 32'd0);
        chk("add_store_data", ex_store_data, 32'd7);
        chk("add_stall_after", 32'(stall_id), 32'd0);
        tick();
        set_id(0, `ALU_OP_ADD, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0,
               32'h0, 32'h0, 0, 0, 5'd13, 1, 1);
        settle();
        chk("pcimm_operand_1", operand_1, 32'h1000);
        chk("pcimm_operand_2", operand_2, 32'h20);
        chk("pcimm_alu_op", 32'(ex_alu_op), 32'(`ALU_OP_SUB));
        chk("pcimm_store_data", ex_store_data, 32'h55);
        chk("pcimm_ex_rd", 32'(ex_rd), 32'd12);
        tick();
        // Invalid ID slot: write enables must be loaded as 0
        chk("inv_ex_valid", 32'(ex_valid), 32'd0);
        chk("inv_ex_reg_write", 32'(ex_reg_write), 32'd0);
        chk("inv_ex_mem_read", 32'(ex_mem_read), 32'd0);

        // lw x2 in EX, dependent load in ID, then flush kills it
        set_id(1, `ALU_OP_ADD, 5'd6, 5'd0, 1, 0, 32'h40, 32'h0,
               32'h180, 32'h8, 0, 1, 5'd2, 1, 1);
        tick();
        set_id(1, `ALU_OP_ADD, 5'd2, 5'd0, 1, 0, 32'h0, 32'h0,
               32'h184, 32'h0, 0, 1, 5'd4, 1, 1);
        settle();
        chk("lu_stall_id", 32'(stall_id), 32'd1);
        flush = 1'b1;
        settle();
        chk("flush_stall_id", 32'(stall_id), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_ex_reg_write", 32'(ex_reg_write), 32'd0);
        chk("flush_ex_mem_read", 32'(ex_mem_read), 32'd0);
        chk("flush_alu_op", 32'(ex_alu_op), 32'(`ALU_OP_ADD));

        // hold freezes EX for 3 cycles while ID presents a new instruction
        set_id(1, `ALU_OP_ADD, 5'd6, 5'd0, 1, 0, 32'h40, 32'h0,
               32'h200, 32'h4, 0, 1, 5'd5, 1, 1);
        tick();
        chk("lw_operand_1", operand_1, 32'h40);
        chk("lw_operand_2", operand_2, 32'h4);
        hold = 1'b1;
        set_id(1, `ALU_OP_SUB, 5'd8, 5'd9, 1, 1, 32'h80, 32'h90,
               32'h300, 32'h0, 0, 0, 5'd7, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ex_rd", 32'(ex_rd), 32'd5);
            chk("hold_ex_mem_read", 32'(ex_mem_read), 32'd1);
            chk("hold_operand_1", operand_1, 32'h40);
            chk("hold_alu_op", 32'(ex_alu_op), 32'(`ALU_OP_ADD));
        end
        hold = 1'b0;
        tick();
        chk("rel_ex_rd", 32'(ex_rd), 32'd7);
        chk("rel_operand_1", operand_1, 32'h80);
        chk("rel_operand_2", operand_2, 32'h90);
        chk("rel_alu_op", 32'(ex_alu_op), 32'(`ALU_OP_SUB));
        chk("rel_ex_mem_read", 32'(ex_mem_read), 32'd0);

        // flush beats hold
        hold = 1'b1; flush = 1'b1;
        tick();
        hold = 1'b0; flush = 1'b0;
        chk("flhold_ex_valid", 32'(ex_valid), 32'd0);
        chk("flhold_ex_reg_write", 32'(ex_reg_write), 32'd0);

        // reset while a stall is pending
        set_id(1, `ALU_OP_ADD, 5'd6, 5'd0, 1, 0, 32'h40, 32'h0,
               32'h200, 32'h4, 0, 1, 5'd5, 1, 1);
        tick();
        set_id(1, `ALU_OP_ADD, 5'd5, 5'd0, 1, 1, 32'h0, 32'h0,
               32'h204, 32'h0, 0, 0, 5'd6, 1, 0);
        settle();
        chk("rststall_before", 32'(stall_id), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rststall_after", 32'(stall_id), 32'd0);
        chk("rststall_ex_valid", 32'(ex_valid), 32'd0);
        chk("rststall_operand_1", operand_1, 32'd0);

`ifdef RISCV_ID_EX_FWD_EN
        // add x3,x1,x2 in EX with MEM/WB producers of x1
        set_id(1, `ALU_OP_ADD, 5'd1, 5'd2, 1, 1, 32'h11, 32'h22,
               32'h0, 32'h0, 0, 0, 5'd3, 1, 0);
        tick();
        set_id(0, `ALU_OP_ADD, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0,
               32'h0, 32'h0, 0, 0, 5'd0, 0, 0);
        mem_rd = 5'd1; mem_reg_write = 1'b1; mem_result = 32'h100;
        wb_rd = 5'd1;  wb_reg_write = 1'b1;  wb_data = 32'h200;
        settle();
        chk("fwd_mem_wins", operand_1, 32'h100);
        mem_reg_write = 1'b0;
        settle();
        chk("fwd_wb", operand_1, 32'h200);
        wb_rd = 5'd2;
        settle();
        chk("fwd_rs1_none", operand_1, 32'h11);
        chk("fwd_rs2_wb", operand_2, 32'h200);
        chk("fwd_store_wb", ex_store_data, 32'h200);
        clr_fwd();
        // x0 is never forwarded
        set_id(1, `ALU_OP_ADD, 5'd0, 5'd0, 1, 1, 32'h77, 32'h66,
               32'h0, 32'h0, 0, 0, 5'd4, 1, 0);
        tick();
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h100;
        wb_rd = 5'd0;  wb_reg_write = 1'b1;  wb_data = 32'h200;
        settle();
        chk("fwd_x0_op1", operand_1, 32'h77);
        chk("fwd_x0_op2", operand_2, 32'h66);
        clr_fwd();
        // load-use: lw x5 then add x6,x5,x0
        set_id(1, `ALU_OP_ADD, 5'd6, 5'd0, 1, 0, 32'h40, 32'h0,
               32'h200, 32'h4, 0, 1, 5'd5, 1, 1);
        tick();
        set_id(1, `ALU_OP_ADD, 5'd5, 5'd0, 1, 1, 32'h1234, 32'h0,
               32'h204, 32'h0, 0, 0, 5'd6, 1, 0);
        settle();
        chk("lu_stall", 32'(stall_id), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_reg_write", 32'(ex_reg_write), 32'd0);
        chk("lu_stall_released", 32'(stall_id), 32'd0);
        mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h44;
        tick();
        clr_fwd();
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 32'hDEADBEEF;
        settle();
        chk("lu_fwd_operand_1", operand_1, 32'hDEADBEEF);
        chk("lu_ex_rd", 32'(ex_rd), 32'd6);
        chk("lu_ex_valid", 32'(ex_valid), 32'd1);
        clr_fwd();
`else
        // addi x1 then add x2,x1,x1: stall while x1 is in EX, MEM and WB
        set_id(1, `ALU_OP_ADD, 5'd0, 5'd0, 1, 0, 32'h0, 32'h0,
               32'h0, 32'h11, 0, 1, 5'd1, 1, 0);
        tick();
        set_id(1, `ALU_OP_ADD, 5'd1, 5'd1, 1, 1, 32'hBAD, 32'hBAD,
               32'h4, 32'h0, 0, 0, 5'd2, 1, 0);
        settle();
        chk("nf_stall_ex", 32'(stall_id), 32'd1);
        tick();
        mem_rd = 5'd1; mem_reg_write = 1'b1;
        settle();
        chk("nf_stall_mem", 32'(stall_id), 32'd1);
        chk("nf_bubble_valid", 32'(ex_valid), 32'd0);
        chk("nf_bubble_reg_write", 32'(ex_reg_write), 32'd0);
        tick();
        clr_fwd();
        wb_rd = 5'd1; wb_reg_write = 1'b1;
        settle();
        chk("nf_stall_wb", 32'(stall_id), 32'd1);
        tick();
        clr_fwd();
        id_rs1_data = 32'h33; id_rs2_data = 32'h33;
        settle();
        chk("nf_stall_clear", 32'(stall_id), 32'd0);
        tick();
        chk("nf_operand_1", operand_1, 32'h33);
        chk("nf_operand_2", operand_2, 32'h33);
        chk("nf_ex_rd", 32'(ex_rd), 32'd2);
        chk("nf_ex_valid", 32'(ex_valid), 32'd1);
        // x0 and unused sources never stall
        set_id(1, `ALU_OP_ADD, 5'd0, 5'd4, 1, 0, 32'h0, 32'h0,
               32'h8, 32'h0, 0, 0, 5'd7, 1, 0);
        mem_rd = 5'd0; mem_reg_write = 1'b1;
        wb_rd = 5'd4;  wb_reg_write = 1'b1;
        settle();
        chk("nf_x0_unused", 32'(stall_id), 32'd0);
        id_uses_rs2 = 1'b1;
        settle();
        chk("nf_rs2_wb", 32'(stall_id), 32'd1);
        clr_fwd();
        settle();
        chk("nf_rs2_clear", 32'(stall_id), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_id_ex_stage.md
# riscv_id_ex_stage

ID/EX pipeline stage directly upstream of the ALU. It registers a decoded instruction from ID and selects the ALU operands. Operand sources are the register file, the PC, the immediate, or data forwarded from the MEM and WB stages. It detects load-use hazards and produces the ID stall, and it inserts bubbles on stall or flush.

## Interface
- No parameters; `ALU_OP_LEN` and `ALU_OP_*` encodings come from `riscv_defs.v`.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_alu_op  in  `ALU_OP_LEN`  decoded ALU operation
- id_rs1, id_rs2  in  5 each  source register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads rs1 / rs2
- id_rs1_data, id_rs2_data  in  32 each  register file read data
- id_pc, id_imm  in  32 each  instruction PC; sign-extended immediate
- id_src1_pc  in  1  operand_1 = PC instead of rs1
- id_src2_imm  in  1  operand_2 = imm instead of rs2
- id_rd  in  5  destination register
- id_reg_write, id_mem_read  in  1 each  instruction writes rd; instruction is a load
- flush  in  1  kill the instruction entering EX (branch/jump redirect)
- hold  in  1  freeze the whole stage (downstream memory stall)
- mem_rd, mem_reg_write, mem_result  in  5/1/32  EX/MEM producer
- wb_rd, wb_reg_write, wb_data  in  5/1/32  MEM/WB producer
- stall_id  out  1  ID and IF must hold (combinational)
- ex_valid, ex_reg_write, ex_mem_read  out  1 each  EX stage control
- ex_rd  out  5  EX destination register
- ex_alu_op  out  `ALU_OP_LEN`  to ALU alu_op
- operand_1, operand_2  out  32 each  to ALU operand_1 / operand_2
- ex_store_data  out  32  forwarded rs2 value, used by stores

## Operation
- Registered EX fields: valid, alu_op, rs1, rs2, uses flags, rs1/rs2 data, pc, imm, src selects, rd, reg_write, mem_read.
- Per-cycle update priority:
  - rst: all fields 0; alu_op = `ALU_OP_ADD`.
  - flush: load a bubble.
  - hold: keep all fields.
  - stall_id: load a bubble.
  - otherwise: load the ID fields. When id_valid=0, reg_write and mem_read are loaded as 0.
- A bubble sets valid, reg_write and mem_read to 0 and alu_op to `ALU_OP_ADD`; the other fields are don't-care.
- Forwarded rsN value, evaluated combinationally on the registered indices:
  - mem_result if mem_reg_write, mem_rd==rsN and rsN!=0;
  - else wb_data if wb_reg_write, wb_rd==rsN and rsN!=0;
  - else the registered rsN data.
  - MEM wins over WB; x0 is never forwarded.
- operand_1 = src1_pc ? pc : fwd_rs1.
- operand_2 = src2_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2.
- stall_id (with forwarding): id_valid && ex_valid && ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- flush forces stall_id low.
- hold does not affect stall_id; ID must also obey hold.

## Timing
- Reset values:
  - stall_id, ex_valid, ex_reg_write, ex_mem_read = 0.
  - ex_rd = 0; ex_alu_op = `ALU_OP_ADD`.
  - operand_1 = operand_2 = ex_store_data = 0.
- Latency: an ID instruction appears at the ALU 1 cycle after the clock edge on which it is accepted.
- Operand outputs are combinational from the registers and the forwarding inputs; there is no added latency.
- A load-use hazard costs exactly 1 bubble. On the next cycle the load is in MEM and its data arrives via WB forwarding one cycle later, so the dependent instruction sees it in EX.
- Simultaneous flush and stall: a bubble is loaded and stall_id=0.
- Simultaneous flush and hold: flush wins.
- Reset mid-stall: stall_id drops on the cycle following reset.

## Configuration
- `RISCV_ID_EX_FWD_EN` defined: forwarding muxes are present, and stall_id covers load-use only, as above.
- `RISCV_ID_EX_FWD_EN` undefined: no forwarding; each fwd_rsN is the registered data.
  - stall_id asserts whenever a used, nonzero ID source matches a writing rd in EX (ex_valid && ex_reg_write), MEM (mem_reg_write) or WB (wb_reg_write).
  - Flush and bubble rules are unchanged.

## Test plan
- Reset, then `add x3,x1,x2` with rs1_data=5, rs2_data=7 and no hazards -> next cycle operand_1=5, operand_2=7, ex_alu_op=`ALU_OP_ADD`, ex_valid=1, stall_id=0.
- EX/MEM match: mem_rd=1, mem_result=0x100 and wb_rd=1, wb_data=0x200 while EX rs1=1 -> operand_1=0x100. With mem_reg_write=0 -> 0x200. With rs1=0 -> registered data (not forwarded).
- Load-use: `lw x5` in EX, `add x6,x5,x0` in ID -> stall_id=1 for 1 cycle and a bubble in EX (ex_reg_write=0). The add then enters EX and operand_1 = wb_data (0xDEADBEEF).
- flush=1 together with a load-use condition -> stall_id=0, next-cycle ex_valid=0, ex_reg_write=0, ex_mem_read=0.
- hold=1 for 3 cycles with new ID inputs -> EX registers unchanged. Releasing hold loads the ID instruction.
- Without `RISCV_ID_EX_FWD_EN`: `addi x1`, then `add x2,x1,x1` -> stall_id high while x1 is in EX, MEM and WB (3 cycles). The add then reads the register-file value.
